// File: rtl/param_reg_file.sv
// -----------------------------------------------------------------------------
// param_reg_file
// Parameterised register file with one write port, two combinational read
// ports, one parity bit per entry, optional write-to-read forwarding and a
// sequenced clear engine that zeroes one entry per clock.
//
// Parameters
//   DW     : data word width in bits
//   PW     : address width, DEPTH = 2**PW entries
//   BYPASS : 1 = a read of the address being written returns the write data
//            in the same cycle; 0 = reads return stored contents only
//
// Ports
//   clk               : clock, all state changes on the rising edge
//   reset             : asynchronous active-high reset, clears all state
//   dat_in/wr_en/wr_addr/inj_err : write port; inj_err flips the stored parity
//   rd_addrA/rd_addrB : read addresses
//   clr_req           : request to start a clear sequence
//   datA_out/datB_out : read data
//   errA/errB         : parity error flag of the word being read
//   regMem            : stored data of the last entry (never forwarded)
//   busy              : clear sequence in progress (CLEAR or DONE)
//   clr_done          : one-cycle pulse in the final cycle of a clear sequence
//   wr_drop           : write attempted while busy and therefore discarded
// -----------------------------------------------------------------------------
module param_reg_file #(
    parameter int DW     = 8,
    parameter int PW     = 4,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] dat_in,
    input  logic          wr_en,
    input  logic [PW-1:0] wr_addr,
    input  logic          inj_err,
    input  logic [PW-1:0] rd_addrA,
    input  logic [PW-1:0] rd_addrB,
    input  logic          clr_req,
    output logic [DW-1:0] datA_out,
    output logic [DW-1:0] datB_out,
    output logic          errA,
    output logic          errB,
    output logic [DW-1:0] regMem,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_drop
);

    localparam int DEPTH = 2 ** PW;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_ptr_next;

    logic          w_busy;
    logic          w_wr_ok;
    logic          w_wr_par;

    logic [DW-1:0] w_data [DEPTH];
    logic          w_par  [DEPTH];

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (clr_req) begin
                    w_state_next = S_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            S_CLEAR: begin
                w_ptr_next = r_ptr + PW'(1);
                if (r_ptr == PW'(DEPTH - 1)) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    assign w_busy   = (r_state != S_IDLE);
    assign busy     = w_busy;
    assign clr_done = (r_state == S_DONE);
    assign wr_drop  = wr_en & w_busy;

    // A write is accepted only in IDLE; reset is included so that the
    // forwarding path cannot leak write data onto the outputs while the
    // block is held in reset.
    assign w_wr_ok  = wr_en & ~w_busy & ~reset;
    assign w_wr_par = (^dat_in) ^ inj_err;

    // ------------------------------------------------------------------
    // Storage: one register per entry so that reset can clear every word
    // asynchronously. The clear engine has priority over the write port,
    // although both can never be active together because writes are
    // blocked while busy.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [DW-1:0] r_data;
            logic          r_par;
            logic          w_clr_hit;
            logic          w_wr_hit;

            assign w_clr_hit = (r_state == S_CLEAR) && (r_ptr == PW'(gi));
            assign w_wr_hit  = w_wr_ok && (wr_addr == PW'(gi));

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_data <= '0;
                    r_par  <= 1'b0;
                end else if (w_clr_hit) begin
                    r_data <= '0;
                    r_par  <= 1'b0;
                end else if (w_wr_hit) begin
                    r_data <= dat_in;
                    r_par  <= w_wr_par;
                end
            end

            assign w_data[gi] = r_data;
            assign w_par[gi]  = r_par;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    logic [DW-1:0] w_rdA_data;
    logic [DW-1:0] w_rdB_data;
    logic          w_rdA_err;
    logic          w_rdB_err;
    logic          w_bypA;
    logic          w_bypB;

    assign w_rdA_data = w_data[rd_addrA];
    assign w_rdB_data = w_data[rd_addrB];
    assign w_rdA_err  = (^w_rdA_data) ^ w_par[rd_addrA];
    assign w_rdB_err  = (^w_rdB_data) ^ w_par[rd_addrB];

    // Forwarded error equals inj_err: the forwarded data XOR its freshly
    // computed parity leaves only the injected inversion.
    assign w_bypA = (BYPASS != 0) && w_wr_ok && (rd_addrA == wr_addr);
    assign w_bypB = (BYPASS != 0) && w_wr_ok && (rd_addrB == wr_addr);

    assign datA_out = w_bypA ? dat_in  : w_rdA_data;
    assign datB_out = w_bypB ? dat_in  : w_rdB_data;
    assign errA     = w_bypA ? inj_err : w_rdA_err;
    assign errB     = w_bypB ? inj_err : w_rdB_err;

    assign regMem   = w_data[DEPTH-1];

endmodule

// File: tb/tb_param_reg_file.sv
// -----------------------------------------------------------------------------
// tb_param_reg_file
// Directed bench for param_reg_file. Three instances: default parameters
// (forwarding on), forwarding off sharing the same stimulus, and a
// DW=16/PW=5 instance with its own write port. Expected values are queued
// when stimulus is driven and popped when the corresponding output is sampled.
// -----------------------------------------------------------------------------
module tb_param_reg_file;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus for the 8/4 instances
    logic       reset;
    logic [7:0] dat_in;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic       inj_err;
    logic [3:0] rd_addrA;
    logic [3:0] rd_addrB;
    logic       clr_req;

    // default instance outputs
    logic [7:0] datA_out, datB_out, regMem;
    logic       errA, errB, busy, clr_done, wr_drop;

    // no-forwarding instance outputs
    logic [7:0] nb_datA, nb_datB, nb_regMem;
    logic       nb_errA, nb_errB, nb_busy, nb_clr_done, nb_wr_drop;

    // wide instance stimulus and outputs
    logic [15:0] w16_dat_in;
    logic        w16_wr_en;
    logic [4:0]  w16_wr_addr;
    logic        w16_inj_err;
    logic [4:0]  w16_rd_addrA;
    logic [4:0]  w16_rd_addrB;
    logic        w16_clr_req;
    logic [15:0] w16_datA, w16_datB, w16_regMem;
    logic        w16_errA, w16_errB, w16_busy, w16_clr_done, w16_wr_drop;

    param_reg_file u_dut (
        .clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en),
        .wr_addr(wr_addr), .inj_err(inj_err), .rd_addrA(rd_addrA),
        .rd_addrB(rd_addrB), .clr_req(clr_req),
        .datA_out(datA_out), .datB_out(datB_out), .errA(errA), .errB(errB),
        .regMem(regMem), .busy(busy), .clr_done(clr_done), .wr_drop(wr_drop)
    );

    param_reg_file #(.DW(8), .PW(4), .BYPASS(0)) u_nb (
        .clk(clk), .reset(reset), .dat_in(dat_in), .wr_en(wr_en),
        .wr_addr(wr_addr), .inj_err(inj_err), .rd_addrA(rd_addrA),
        .rd_addrB(rd_addrB), .clr_req(clr_req),
        .datA_out(nb_datA), .datB_out(nb_datB), .errA(nb_errA), .errB(nb_errB),
        .regMem(nb_regMem), .busy(nb_busy), .clr_done(nb_clr_done),
        .wr_drop(nb_wr_drop)
    );

    param_reg_file #(.DW(16), .PW(5), .BYPASS(1)) u_wide (
        .clk(clk), .reset(reset), .dat_in(w16_dat_in), .wr_en(w16_wr_en),
        .wr_addr(w16_wr_addr), .inj_err(w16_inj_err), .rd_addrA(w16_rd_addrA),
        .rd_addrB(w16_rd_addrB), .clr_req(w16_clr_req),
        .datA_out(w16_datA), .datB_out(w16_datB), .errA(w16_errA),
        .errB(w16_errB), .regMem(w16_regMem), .busy(w16_busy),
        .clr_done(w16_clr_done), .wr_drop(w16_wr_drop)
    );

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic expect_v(input string tag, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic check_v(input logic [31:0] obs);
        exp_t e;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty observed=%h expected=<none>", obs);
        end else begin
            e = sb_q.pop_front();
            $display("[%0t] %s observed=%h expected=%h", $time, e.tag, obs, e.exp);
            assert (obs === e.exp) else begin
                mismatched++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] model [16];
    int busy_cnt, done_cnt, done_at, busy2, done2;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---- reset, with a write attempt that must stay invisible ----
        reset = 1'b1; dat_in = 8'hEE; wr_en = 1'b1; wr_addr = 4'd3;
        inj_err = 1'b0; rd_addrA = 4'd3; rd_addrB = 4'd3; clr_req = 1'b0;
        w16_dat_in = '0; w16_wr_en = 1'b0; w16_wr_addr = '0; w16_inj_err = 1'b0;
        w16_rd_addrA = '0; w16_rd_addrB = '0; w16_clr_req = 1'b0;
        #2;
        expect_v("rst_datA", 0); expect_v("rst_datB", 0); expect_v("rst_errA", 0);
        expect_v("rst_errB", 0); expect_v("rst_regMem", 0); expect_v("rst_busy", 0);
        expect_v("rst_clr_done", 0); expect_v("rst_wr_drop", 0); expect_v("rst_w16_regMem", 0);
        check_v(datA_out); check_v(datB_out); check_v(errA); check_v(errB);
        check_v(regMem); check_v(busy); check_v(clr_done); check_v(wr_drop);
        check_v(w16_regMem);
        repeat (2) next_cycle();
        reset = 1'b0; wr_en = 1'b0;
        expect_v("post_rst_entry3", 0);
        @(negedge clk); check_v(datA_out);
        next_cycle();

        // ---- basic write then read ----
        wr_en = 1'b1; wr_addr = 4'd3; dat_in = 8'hA5; rd_addrA = 4'd0;
        expect_v("idle_wr_drop", 0);
        @(negedge clk); check_v(wr_drop);
        next_cycle();
        wr_en = 1'b0; rd_addrA = 4'd3;
        expect_v("rd3_datA", 8'hA5); expect_v("rd3_errA", 0);
        @(negedge clk); check_v(datA_out); check_v(errA);
        next_cycle();

        // ---- forwarding on vs off ----
        wr_en = 1'b1; wr_addr = 4'd7; dat_in = 8'h3C; rd_addrB = 4'd7;
        expect_v("byp_datB", 8'h3C); expect_v("byp_errB", 0); expect_v("nobyp_datB", 8'h00);
        @(negedge clk); check_v(datB_out); check_v(errB); check_v(nb_datB);
        next_cycle();
        wr_en = 1'b0;
        expect_v("nobyp_datB_after", 8'h3C);
        @(negedge clk); check_v(nb_datB);
        next_cycle();

        // ---- parity fault injection ----
        wr_en = 1'b1; wr_addr = 4'd2; dat_in = 8'h01; inj_err = 1'b1; rd_addrB = 4'd2;
        expect_v("inj_byp_datB", 8'h01); expect_v("inj_byp_errB", 1);
        @(negedge clk); check_v(datB_out); check_v(errB);
        next_cycle();
        wr_en = 1'b0; inj_err = 1'b0; rd_addrA = 4'd2;
        expect_v("inj_datA", 8'h01); expect_v("inj_errA", 1); expect_v("inj_nb_errB", 1);
        @(negedge clk); check_v(datA_out); check_v(errA); check_v(nb_errB);
        next_cycle();
        wr_en = 1'b1; wr_addr = 4'd2; dat_in = 8'h01; inj_err = 1'b0;
        next_cycle();
        wr_en = 1'b0;
        expect_v("fix_errA", 0);
        @(negedge clk); check_v(errA);
        next_cycle();

        // ---- regMem on both geometries ----
        wr_en = 1'b1; wr_addr = 4'd15; dat_in = 8'hFF;
        w16_wr_en = 1'b1; w16_wr_addr = 5'd31; w16_dat_in = 16'h00FF; w16_rd_addrA = 5'd31;
        expect_v("regMem_no_fwd", 0); expect_v("w16_regMem_no_fwd", 0);
        @(negedge clk); check_v(regMem); check_v(w16_regMem);
        next_cycle();
        wr_en = 1'b0; w16_wr_en = 1'b0;
        expect_v("regMem", 8'hFF); expect_v("w16_regMem", 16'h00FF); expect_v("w16_datA", 16'h00FF);
        @(negedge clk); check_v(regMem); check_v(w16_regMem); check_v(w16_datA);
        next_cycle();

        // ---- fill all entries and read back on both ports ----
        for (int i = 0; i < 15; i++) model[i] = 8'(i * 37 + 5);
        model[15] = 8'hFF;
        for (int i = 0; i < 15; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); dat_in = model[i];
            next_cycle();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd_addrA = 4'(i); rd_addrB = 4'(15 - i);
            expect_v($sformatf("fill_A%0d", i), model[i]);
            expect_v($sformatf("fill_B%0d", 15 - i), model[15 - i]);
            @(negedge clk); check_v(datA_out); check_v(datB_out);
            next_cycle();
        end

        // ---- clear sequence, with a same-cycle write at the start ----
        wr_en = 1'b1; wr_addr = 4'd4; dat_in = 8'h77; clr_req = 1'b1;
        next_cycle();
        busy_cnt = 0; done_cnt = 0; done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            wr_en = 1'b0; clr_req = 1'b0;
            if (c == 1) begin
                rd_addrA = 4'd4; rd_addrB = 4'd15;
                expect_v("clr_c1_wr_landed", 8'h77); expect_v("clr_c1_entry15_old", 8'hFF);
            end
            if (c == 3) begin
                rd_addrA = 4'd0;
                expect_v("clr_c3_entry0", 0); expect_v("clr_c3_errA", 0);
            end
            if (c == 5) begin
                wr_en = 1'b1; wr_addr = 4'd0; dat_in = 8'h99; clr_req = 1'b1; rd_addrB = 4'd0;
                expect_v("clr_wr_drop", 1); expect_v("clr_no_fwd_datB", 0);
            end
            @(negedge clk);
            if (c == 1) begin check_v(datA_out); check_v(datB_out); end
            if (c == 3) begin check_v(datA_out); check_v(errA); end
            if (c == 5) begin check_v(wr_drop); check_v(datB_out); end
            if (!busy) break;
            busy_cnt++;
            if (clr_done) begin
                done_cnt++;
                done_at = c;
            end
            next_cycle();
        end
        expect_v("busy_cycles", 17); expect_v("clr_done_cycle", 17); expect_v("clr_done_pulses", 1);
        check_v(busy_cnt); check_v(done_at); check_v(done_cnt);
        next_cycle();
        for (int i = 0; i < 16; i++) begin
            rd_addrA = 4'(i); rd_addrB = 4'(i);
            expect_v($sformatf("cleared_A%0d", i), 0);
            expect_v($sformatf("cleared_errB%0d", i), 0);
            @(negedge clk); check_v(datA_out); check_v(errB);
            next_cycle();
        end
        expect_v("cleared_regMem", 0); expect_v("idle_busy", 0); expect_v("idle_drop", 0);
        @(negedge clk); check_v(regMem); check_v(busy); check_v(wr_drop);
        next_cycle();

        // ---- reset in the middle of a clear sequence ----
        wr_en = 1'b1; wr_addr = 4'd9; dat_in = 8'hC3;
        next_cycle();
        wr_addr = 4'd15; dat_in = 8'h5A;
        next_cycle();
        wr_en = 1'b0; rd_addrA = 4'd9;
        expect_v("pre_regMem", 8'h5A); expect_v("pre_datA9", 8'hC3);
        @(negedge clk); check_v(regMem); check_v(datA_out);
        next_cycle();
        clr_req = 1'b1;
        next_cycle();
        clr_req = 1'b0;
        repeat (4) next_cycle();
        expect_v("midclr_busy", 1);
        check_v(busy);
        wr_en = 1'b1; wr_addr = 4'd9; dat_in = 8'h33; rd_addrA = 4'd9; rd_addrB = 4'd15;
        #1 reset = 1'b1;
        #1;
        expect_v("arst_datA", 0); expect_v("arst_datB", 0); expect_v("arst_regMem", 0);
        expect_v("arst_errA", 0); expect_v("arst_busy", 0); expect_v("arst_clr_done", 0);
        expect_v("arst_wr_drop", 0);
        check_v(datA_out); check_v(datB_out); check_v(regMem); check_v(errA);
        check_v(busy); check_v(clr_done); check_v(wr_drop);
        next_cycle();
        reset = 1'b0; wr_en = 1'b0;
        busy2 = 0; done2 = 0;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            if (clr_done) done2++;
            if (busy) busy2++;
            next_cycle();
        end
        expect_v("post_abort_done_pulses", 0); expect_v("post_abort_busy_cycles", 0);
        expect_v("post_abort_entry9", 0);
        check_v(done2); check_v(busy2);
        @(negedge clk); check_v(datA_out);

        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
